// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sharing block: opcodes, datapath width and FSM states.
package alu_pkg;

   localparam int ALU_W = 32;

   localparam logic [1:0] ALU_ADD = 2'd0;
   localparam logic [1:0] ALU_SUB = 2'd1;
   localparam logic [1:0] ALU_MUL = 2'd2;
   localparam logic [1:0] ALU_NOP = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_RESP = 2'd2
   } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr, modulo N.
module rr_arbiter #(
   parameter int N    = 4,
   parameter int IDXW = 2
) (
   input  logic [N-1:0]    req,
   input  logic [IDXW-1:0] ptr,
   output logic [N-1:0]    grant,
   output logic [IDXW-1:0] idx,
   output logic            any
);

   // Scan offsets from farthest to nearest so the closest request to ptr is kept last.
   always_comb begin
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      for (int k = N - 1; k >= 0; k--) begin
         int j;
         j = (int'(ptr) + k) % N;
         if (req[j]) begin
            grant    = '0;
            grant[j] = 1'b1;
            idx      = IDXW'(j);
            any      = 1'b1;
         end else begin
            any = any;
         end
      end
   end

endmodule

// File: rtl/alu_share_arbiter.sv
// Time-shares one external combinational ALU among N_REQ requesters with round-robin
// arbitration; one operation in flight, registered operands and registered tagged result.
module alu_share_arbiter
   import alu_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int W     = ALU_W,
   parameter int IDW   = $clog2(N_REQ)
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [N_REQ-1:0]     io_req_valid,
   output logic [N_REQ-1:0]     io_req_ready,
   input  logic [N_REQ*W-1:0]   io_req_A,
   input  logic [N_REQ*W-1:0]   io_req_B,
   input  logic [N_REQ*2-1:0]   io_req_op,
   output logic [W-1:0]         io_alu_A,
   output logic [W-1:0]         io_alu_B,
   output logic [1:0]           io_alu_op,
   input  logic [W-1:0]         io_alu_out,
   output logic                 io_resp_valid,
   input  logic                 io_resp_ready,
   output logic [IDW-1:0]       io_resp_id,
   output logic [W-1:0]         io_resp_data,
   output logic                 io_busy
);

   state_t           state_r;
   logic [IDW-1:0]   rr_ptr_r;
   logic [IDW-1:0]   id_r;
   logic [N_REQ-1:0] grant_s;
   logic [IDW-1:0]   grant_idx_s;
   logic             grant_any_s;
   logic [IDW-1:0]   next_ptr_s;

   rr_arbiter #(
      .N    (N_REQ),
      .IDXW (IDW)
   ) u_rr_arbiter (
      .req   (io_req_valid),
      .ptr   (rr_ptr_r),
      .grant (grant_s),
      .idx   (grant_idx_s),
      .any   (grant_any_s)
   );

   // Ready is only offered while idle and out of reset, so a grant always implies a handshake.
   always_comb begin
      if (state_r == S_IDLE && !reset && grant_any_s) begin
         io_req_ready = grant_s;
      end else begin
         io_req_ready = '0;
      end
   end

   // Pointer moves one past the winner, wrapping explicitly for non power-of-two N_REQ.
   always_comb begin
      if (grant_idx_s == IDW'(N_REQ - 1)) begin
         next_ptr_s = '0;
      end else begin
         next_ptr_s = grant_idx_s + IDW'(1);
      end
   end

   // Control FSM with all outputs registered.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r       <= S_IDLE;
         rr_ptr_r      <= '0;
         id_r          <= '0;
         io_alu_A      <= '0;
         io_alu_B      <= '0;
         io_alu_op     <= 2'd0;
         io_resp_valid <= 1'b0;
         io_resp_id    <= '0;
         io_resp_data  <= '0;
         io_busy       <= 1'b0;
      end else begin
         case (state_r)
            S_IDLE: begin
               if (grant_any_s) begin
                  io_alu_A  <= io_req_A[int'(grant_idx_s)*W +: W];
                  io_alu_B  <= io_req_B[int'(grant_idx_s)*2*0 + int'(grant_idx_s)*W +: W];
                  io_alu_op <= io_req_op[int'(grant_idx_s)*2 +: 2];
                  id_r      <= grant_idx_s;
                  rr_ptr_r  <= next_ptr_s;
                  io_busy   <= 1'b1;
                  state_r   <= S_EXEC;
               end else begin
                  state_r <= S_IDLE;
               end
            end
            S_EXEC: begin
               io_resp_data  <= io_alu_out;
               io_resp_id    <= id_r;
               io_resp_valid <= 1'b1;
               state_r       <= S_RESP;
            end
            S_RESP: begin
               if (io_resp_ready) begin
                  io_resp_valid <= 1'b0;
                  io_busy       <= 1'b0;
                  state_r       <= S_IDLE;
               end else begin
                  state_r <= S_RESP;
               end
            end
            default: begin
               io_resp_valid <= 1'b0;
               io_busy       <= 1'b0;
               state_r       <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural ALU attached to the ALU port.
module tb_alu_share_arbiter;

   logic         clock = 1'b0;
   logic         reset;
   logic [3:0]   req_valid;
   logic [3:0]   req_ready;
   logic [127:0] req_A;
   logic [127:0] req_B;
   logic [7:0]   req_op;
   logic [31:0]  alu_A, alu_B, alu_out, resp_data;
   logic [1:0]   alu_op, resp_id;
   logic         resp_valid, resp_ready, busy;

   int checks   = 0;
   int failures = 0;

   alu_share_arbiter dut (
      .clock         (clock),
      .reset         (reset),
      .io_req_valid  (req_valid),
      .io_req_ready  (req_ready),
      .io_req_A      (req_A),
      .io_req_B      (req_B),
      .io_req_op     (req_op),
      .io_alu_A      (alu_A),
      .io_alu_B      (alu_B),
      .io_alu_op     (alu_op),
      .io_alu_out    (alu_out),
      .io_resp_valid (resp_valid),
      .io_resp_ready (resp_ready),
      .io_resp_id    (resp_id),
      .io_resp_data  (resp_data),
      .io_busy       (busy)
   );

   always #5 clock = ~clock;

   // Behavioural ALU: wrap add/sub, low 32 bits of mul, op 3 gives zero.
   always_comb begin
      case (alu_op)
         2'd0:    alu_out = alu_A + alu_B;
         2'd1:    alu_out = alu_A - alu_B;
         2'd2:    alu_out = alu_A * alu_B;
         default: alu_out = 32'd0;
      endcase
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] op);
      req_A[i*32 +: 32] = a;
      req_B[i*32 +: 32] = b;
      req_op[i*2 +: 2]  = op;
   endtask

   initial begin
      reset      = 1'b1;
      req_valid  = 4'h0;
      req_A      = '0;
      req_B      = '0;
      req_op     = '0;
      resp_ready = 1'b1;

      // Reset state; ready must stay low while reset is high even with requests pending
      step();
      req_valid = 4'hF;
      #1;
      chk("ready_in_reset", {28'd0, req_ready}, 32'h0);
      step();
      req_valid = 4'h0;
      reset     = 1'b0;
      #1;
      chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_alu_A", alu_A, 32'd0);
      chk("rst_alu_op", {30'd0, alu_op}, 32'd0);
      chk("rst_resp_id", {30'd0, resp_id}, 32'd0);
      chk("rst_resp_data", resp_data, 32'd0);

      // 1: single ADD from req0, response two cycles after handshake
      set_req(0, 32'd5, 32'd7, 2'd0);
      req_valid = 4'b0001;
      #1;
      chk("t1_ready", {28'd0, req_ready}, 32'h1);
      step();
      req_valid = 4'h0;
      #1;
      chk("t1_exec_resp_valid", {31'd0, resp_valid}, 32'd0);
      chk("t1_exec_busy", {31'd0, busy}, 32'd1);
      chk("t1_alu_A", alu_A, 32'd5);
      chk("t1_alu_B", alu_B, 32'd7);
      step();
      chk("t1_resp_valid", {31'd0, resp_valid}, 32'd1);
      chk("t1_data", resp_data, 32'd12);
      chk("t1_id", {30'd0, resp_id}, 32'd0);
      step();
      chk("t1_drained", {31'd0, resp_valid}, 32'd0);
      chk("t1_idle_busy", {31'd0, busy}, 32'd0);

      // 2: all four valid from pointer 0 -> grants 0,1,2,3,0 every 3 cycles
      reset = 1'b1;
      step();
      reset = 1'b0;
      for (int i = 0; i < 4; i++) set_req(i, 32'd100 + 32'(i), 32'(i), 2'd0);
      req_valid = 4'hF;
      #1;
      for (int k = 0; k < 5; k++) begin
         chk("t2_grant", {28'd0, req_ready}, 32'd1 << (k % 4));
         step();
         chk("t2_exec_ready", {28'd0, req_ready}, 32'h0);
         step();
         chk("t2_resp_valid", {31'd0, resp_valid}, 32'd1);
         chk("t2_id", {30'd0, resp_id}, 32'(k % 4));
         chk("t2_data", resp_data, 32'd100 + 32'(2 * (k % 4)));
         chk("t2_resp_ready_low", {28'd0, req_ready}, 32'h0);
         step();
      end
      req_valid = 4'h0;

      // 3: SUB underflow from req2 with response back-pressure (pointer now 1)
      set_req(2, 32'd0, 32'd1, 2'd1);
      req_valid = 4'b0100;
      #1;
      chk("t3_ready", {28'd0, req_ready}, 32'h4);
      resp_ready = 1'b0;
      step();
      req_valid = 4'b1011;
      step();
      for (int c = 0; c < 5; c++) begin
         chk("t3_hold_valid", {31'd0, resp_valid}, 32'd1);
         chk("t3_hold_data", resp_data, 32'hFFFF_FFFF);
         chk("t3_hold_id", {30'd0, resp_id}, 32'd2);
         chk("t3_hold_ready", {28'd0, req_ready}, 32'h0);
         step();
      end
      resp_ready = 1'b1;
      #1;
      chk("t3_drain_ready", {28'd0, req_ready}, 32'h0);
      req_valid = 4'h0;
      step();
      chk("t3_drained", {31'd0, resp_valid}, 32'd0);

      // 4: MUL overflow from req1 (pointer 3, search 3,0,1)
      set_req(1, 32'h0001_0000, 32'h0001_0000, 2'd2);
      req_valid = 4'b0010;
      #1;
      chk("t4_mul_ready", {28'd0, req_ready}, 32'h2);
      step();
      req_valid = 4'h0;
      step();
      chk("t4_mul_data", resp_data, 32'd0);
      chk("t4_mul_id", {30'd0, resp_id}, 32'd1);
      step();

      // 4/6: op 3 from req1 with pointer 2 and req3 idle -> wrap search finds req1
      set_req(1, 32'd3, 32'd4, 2'd3);
      req_valid = 4'b0010;
      #1;
      chk("t6_wrap_ready", {28'd0, req_ready}, 32'h2);
      step();
      req_valid = 4'h0;
      #1;
      chk("t4_op3_passthru", {30'd0, alu_op}, 32'd3);
      step();
      chk("t4_op3_data", resp_data, 32'd0);
      chk("t4_op3_id", {30'd0, resp_id}, 32'd1);
      step();
      // pointer must be 2 now: req1 and req2 both valid -> req2 wins
      set_req(2, 32'd9, 32'd4, 2'd1);
      req_valid = 4'b0110;
      #1;
      chk("t6_ptr_after_wrap", {28'd0, req_ready}, 32'h4);
      step();
      req_valid = 4'h0;
      step();
      chk("t6_data", resp_data, 32'd5);
      step();

      // 5: reset during EXEC aborts; pointer returns to 0 (would be 3 otherwise)
      set_req(2, 32'd1, 32'd1, 2'd0);
      req_valid = 4'b0100;
      #1;
      chk("t5_ready", {28'd0, req_ready}, 32'h4);
      step();
      req_valid = 4'h0;
      reset     = 1'b1;
      step();
      chk("t5_resp_valid", {31'd0, resp_valid}, 32'd0);
      chk("t5_busy", {31'd0, busy}, 32'd0);
      chk("t5_alu_A", alu_A, 32'd0);
      reset = 1'b0;
      set_req(0, 32'd20, 32'd3, 2'd2);
      set_req(3, 32'd1, 32'd1, 2'd0);
      req_valid = 4'b1001;
      #1;
      chk("t5_grant_req0", {28'd0, req_ready}, 32'h1);
      step();
      req_valid = 4'h0;
      step();
      chk("t5_data", resp_data, 32'd60);
      chk("t5_id", {30'd0, resp_id}, 32'd0);
      step();
      chk("t5_idle", {31'd0, busy}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
